// File: rtl/arb8_rr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : arb8_rr_ctrl_if
//  Description : Request/grant bundle between eight requesters and the
//                round-robin arbiter. The master side drives enable and
//                requests. The slave side (the arbiter) returns the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
interface arb8_rr_ctrl_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld
    );
endinterface
`default_nettype wire

// File: rtl/arb8_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arb8_rr_ctrl
//  Description : Eight-way round-robin arbiter with a registered one-hot
//                grant, its encoded index, and a bounded tenure. Under
//                contention the owner is rotated out after MAX_HOLD cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb8_rr_ctrl #(
    parameter int MAX_HOLD = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    arb8_rr_ctrl_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    logic [0:0] state,    state_nx;
    logic [7:0] gnt_reg,  gnt_nx;
    logic [2:0] idx_reg,  idx_nx;
    logic       vld_reg,  vld_nx;
    logic [2:0] ptr,      ptr_nx;
    logic [3:0] cnt,      cnt_nx;

    logic [2:0] after_owner;
    logic [7:0] others;
    logic [3:0] idle_pick;
    logic [3:0] rel_pick;
    logic [3:0] rot_pick;

    // Scan r starting at 'start', wrapping 7->0. Result is {found, index}.
    // The loop runs from the farthest offset down so the nearest hit wins.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign after_owner = idx_reg + 3'd1;
    assign others      = bus.req & ~gnt_reg;
    assign idle_pick   = pick(bus.req, ptr);
    assign rel_pick    = pick(bus.req, after_owner);
    assign rot_pick    = pick(others, after_owner);

    // Next-state decision: IDLE acquires, GRANT handles drop/release/rotate/hold.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_reg;
        idx_nx   = idx_reg;
        vld_nx   = vld_reg;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    gnt_nx   = 8'd1 << idle_pick[2:0];
                    idx_nx   = idle_pick[2:0];
                    vld_nx   = 1'b1;
                    cnt_nx   = 4'd1;
                    state_nx = GRANT;
                end else begin
                    gnt_nx = 8'h00;
                    idx_nx = 3'd0;
                    vld_nx = 1'b0;
                    cnt_nx = 4'd0;
                end
            end
            GRANT: begin
                if (!bus.en) begin
                    gnt_nx   = 8'h00;
                    idx_nx   = 3'd0;
                    vld_nx   = 1'b0;
                    cnt_nx   = 4'd0;
                    ptr_nx   = after_owner;
                    state_nx = IDLE;
                end else if (!bus.req[idx_reg]) begin
                    // Owner released: hand off in the same edge if anyone waits.
                    ptr_nx = after_owner;
                    if (rel_pick[3]) begin
                        gnt_nx = 8'd1 << rel_pick[2:0];
                        idx_nx = rel_pick[2:0];
                        vld_nx = 1'b1;
                        cnt_nx = 4'd1;
                    end else begin
                        gnt_nx   = 8'h00;
                        idx_nx   = 3'd0;
                        vld_nx   = 1'b0;
                        cnt_nx   = 4'd0;
                        state_nx = IDLE;
                    end
                end else if ((cnt == HOLD_LIM) && (|others)) begin
                    // Tenure exhausted under contention: force the next requester in.
                    gnt_nx = 8'd1 << rot_pick[2:0];
                    idx_nx = rot_pick[2:0];
                    vld_nx = 1'b1;
                    cnt_nx = 4'd1;
                    ptr_nx = after_owner;
                end else if (cnt != HOLD_LIM) begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 8'h00;
                idx_nx   = 3'd0;
                vld_nx   = 1'b0;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_reg <= 8'h00;
            idx_reg <= 3'd0;
            vld_reg <= 1'b0;
            ptr     <= 3'd0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_nx;
            gnt_reg <= gnt_nx;
            idx_reg <= idx_nx;
            vld_reg <= vld_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.gnt_idx = idx_reg;
    assign bus.gnt_vld = vld_reg;

endmodule
`default_nettype wire

// File: tb/tb_arb8_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb8_rr_ctrl
//  Description : Directed self-checking bench for arb8_rr_ctrl (MAX_HOLD=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb8_rr_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb8_rr_ctrl_if bus ();

    arb8_rr_ctrl #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, ".gnt"},     bus.gnt,                g);
        check({tag, ".gnt_idx"}, {5'd0, bus.gnt_idx},    {5'd0, i});
        check({tag, ".gnt_vld"}, {7'd0, bus.gnt_vld},    {7'd0, v});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;

        // Reset state
        #3;
        check_grant("reset", 8'h00, 3'd0, 1'b0);
        step();
        step();
        check_grant("reset_held", 8'h00, 3'd0, 1'b0);

        // First grant after reset goes to lowest set index
        rst_n   = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'h81;
        step();
        check_grant("first_grant", 8'h01, 3'd0, 1'b1);

        // Asynchronous reset mid-grant, no clock edge in between
        rst_n = 1'b0;
        #2;
        check_grant("async_reset", 8'h00, 3'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_grant("post_reset_grant", 8'h01, 3'd0, 1'b1);

        // Release to idle
        bus.req = 8'h00;
        step();
        check_grant("release_idle", 8'h00, 3'd0, 1'b0);

        // Single-request sweep
        for (int i = 0; i < 8; i++) begin
            bus.req = 8'd1 << i;
            for (int c = 0; c < 3; c++) begin
                step();
                check_grant($sformatf("sweep%0d", i), 8'd1 << i, 3'(i), 1'b1);
            end
            bus.req = 8'h00;
            step();
            check_grant($sformatf("sweep_gap%0d", i), 8'h00, 3'd0, 1'b0);
        end

        // Full contention: each owner for exactly 4 cycles, ptr starts at 0
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_grant($sformatf("contend%0d_%0d", k, c), 8'd1 << (k % 8), 3'(k % 8), 1'b1);
            end
        end

        // Early release: reset first so ptr=0
        rst_n = 1'b0;
        #1;
        rst_n   = 1'b1;
        bus.req = 8'h05;
        step();
        check_grant("early_own0_a", 8'h01, 3'd0, 1'b1);
        step();
        check_grant("early_own0_b", 8'h01, 3'd0, 1'b1);
        bus.req = 8'h04;
        step();
        check_grant("early_handoff", 8'h04, 3'd2, 1'b1);
        bus.req = 8'h00;
        step();
        check_grant("early_drop", 8'h00, 3'd0, 1'b0);

        // Enable gating
        bus.req = 8'h01;
        step();
        check_grant("en_own0", 8'h01, 3'd0, 1'b1);
        bus.en = 1'b0;
        step();
        check_grant("en_off", 8'h00, 3'd0, 1'b0);
        step();
        check_grant("en_off_hold", 8'h00, 3'd0, 1'b0);
        bus.en  = 1'b1;
        bus.req = 8'h03;
        step();
        check_grant("en_on_ptr1", 8'h02, 3'd1, 1'b1);

        // Lone holder: owner 1 drops while 4 requests on the same edge
        bus.req = 8'h10;
        for (int c = 0; c < 20; c++) begin
            step();
            check_grant($sformatf("lone%0d", c), 8'h10, 3'd4, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
